// File: rtl/aes_cmd_pkg.sv
// Shared types for the AES command sequencer: opcodes, response status codes,
// sequencer FSM states and the opcode-to-start-vector mapping.
package aes_cmd_pkg;

    typedef enum logic [1:0] {
        OP_KEYG = 2'b00,
        OP_ENCR = 2'b01,
        OP_DECR = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_NOKEY   = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_BADOP   = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

    localparam int START_W = 3;
    localparam int RESULT_W = 128;

    // Bit 0 keygen, bit 1 encrypt, bit 2 decrypt; the reserved opcode maps to no start.
    function automatic logic [START_W-1:0] op_to_onehot(input op_e op);
        logic [START_W-1:0] vec;
        vec = '0;
        case (op)
            OP_KEYG: vec = 3'b001;
            OP_ENCR: vec = 3'b010;
            OP_DECR: vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/aes_cmd_timer.sv
// Clearable up-counter with a terminal-count flag raised when the count
// reaches TIMEOUT_CYCLES-1; used to bound the wait for the AES core.
module aes_cmd_timer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_tc = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/aes_cmd_sequencer.sv
// Host-side command initiator for the AES core: accepts keygen/encrypt/decrypt
// requests, pulses the core start, waits for done with a timeout and returns
// a buffered result/status. Optional counters under AES_CMD_STATS_EN.
module aes_cmd_sequencer
    import aes_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    input  logic [1:0]          i_req_op,
    output logic                o_req_ready,
    output logic [START_W-1:0]  o_aes_start,
    input  logic                i_aes_busy,
    input  logic                i_aes_done,
    input  logic [RESULT_W-1:0] i_aes_result,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [RESULT_W-1:0] o_rsp_data,
    output logic [1:0]          o_rsp_status,
    output logic                o_key_valid,
    output logic [15:0]         o_ok_cnt,
    output logic [15:0]         o_err_cnt
);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    op_e                   req_op;
    logic [START_W-1:0]    start_q, start_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [RESULT_W-1:0]   rsp_data_q, rsp_data_d;
    status_e               status_q, status_d;
    logic                  key_valid_q, key_valid_d;
    logic                  timer_clr, timer_en, timer_tc;

    assign req_op      = op_e'(i_req_op);
    assign o_req_ready = (state_q == S_IDLE) && !i_aes_busy;

    aes_cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_clr(timer_clr),
        .i_en (timer_en),
        .o_tc (timer_tc)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        start_d     = '0;
        rsp_data_d  = rsp_data_q;
        status_d    = status_q;
        key_valid_d = key_valid_q;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_req_valid && o_req_ready) begin
                    op_d = req_op;
                    if (req_op == OP_RSVD) begin
                        state_d    = S_RESP;
                        status_d   = ST_BADOP;
                        rsp_data_d = '0;
                    end else if (req_op != OP_KEYG && !key_valid_q) begin
                        state_d    = S_RESP;
                        status_d   = ST_NOKEY;
                        rsp_data_d = '0;
                    end else begin
                        // Registered start appears in ISSUE, the cycle after accept.
                        state_d = S_ISSUE;
                        start_d = op_to_onehot(req_op);
                    end
                end
            end
            S_ISSUE: begin
                timer_clr = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // Done takes priority over a timeout on the same cycle.
                if (i_aes_done) begin
                    state_d  = S_RESP;
                    status_d = ST_OK;
                    if (op_q == OP_KEYG) begin
                        rsp_data_d  = '0;
                        key_valid_d = 1'b1;
                    end else begin
                        rsp_data_d = i_aes_result;
                    end
                end else if (timer_tc) begin
                    state_d    = S_RESP;
                    status_d   = ST_TIMEOUT;
                    rsp_data_d = '0;
                    if (op_q == OP_KEYG) begin
                        key_valid_d = 1'b0;
                    end
                end else begin
                    timer_en = 1'b1;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_KEYG;
            start_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            status_q    <= ST_OK;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            status_q    <= status_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign o_aes_start  = start_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_data   = rsp_data_q;
    assign o_rsp_status = status_q;
    assign o_key_valid  = key_valid_q;

`ifdef AES_CMD_STATS_EN
    logic [15:0] ok_cnt_q, err_cnt_q;
    logic        rsp_fire;

    assign rsp_fire = (state_q == S_RESP) && i_rsp_ready;

    // Saturating per-status tallies, bumped once per response handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (rsp_fire) begin
            if (status_q == ST_OK) begin
                if (ok_cnt_q != 16'hFFFF) ok_cnt_q <= ok_cnt_q + 16'd1;
            end else begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign o_ok_cnt  = ok_cnt_q;
    assign o_err_cnt = err_cnt_q;
`else
    assign o_ok_cnt  = '0;
    assign o_err_cnt = '0;
`endif

endmodule
